// File: rtl/ycbcr444_to_422.sv
// ---------------------------------------------------------------------------
// ycbcr444_to_422
//
// Converts a 4:4:4 YCbCr pixel stream to 4:2:2 with a fixed 2-cycle latency.
// Each even/odd pixel pair within a line shares one rounded Cb average (sent
// on the even pixel) and one rounded Cr average (sent on the odd pixel). An
// even pixel that ends its line passes its own Cb through and drops its Cr.
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   y_i       : luma in
//   cb_i      : blue chroma in (offset-128)
//   cr_i      : red chroma in (offset-128)
//   de_i      : data enable, marks a pixel
//   hs_i      : horizontal sync
//   vs_i      : vertical sync
//   bypass_i  : sideband, delayed untouched
//   y_o       : luma out, 2 cycles late
//   c_o       : interleaved chroma out (Cb even, Cr odd), 0 when de_o = 0
//   de_o      : data enable out, 2 cycles late
//   hs_o      : hsync out, 2 cycles late
//   vs_o      : vsync out, 2 cycles late
//   bypass_o  : sideband out, 2 cycles late
// ---------------------------------------------------------------------------
module ycbcr444_to_422 #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int BYPASS_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PIXEL_WIDTH-1:0]  y_i,
    input  logic [PIXEL_WIDTH-1:0]  cb_i,
    input  logic [PIXEL_WIDTH-1:0]  cr_i,
    input  logic                    de_i,
    input  logic                    hs_i,
    input  logic                    vs_i,
    input  logic [BYPASS_WIDTH-1:0] bypass_i,
    output logic [PIXEL_WIDTH-1:0]  y_o,
    output logic [PIXEL_WIDTH-1:0]  c_o,
    output logic                    de_o,
    output logic                    hs_o,
    output logic                    vs_o,
    output logic [BYPASS_WIDTH-1:0] bypass_o
);

    localparam int W = PIXEL_WIDTH;

    // Rounded (half-up) average of two components; the one-bit-wider sum
    // makes overflow impossible, and bits [W:1] are the result after >>1.
    function automatic logic [W-1:0] avg_round(
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
        return sum[W:1];
    endfunction

    // Stage-1 shift registers (one cycle behind the inputs)
    logic [W-1:0]            y_d1_r;
    logic [W-1:0]            cb_d1_r;
    logic [W-1:0]            cr_d1_r;
    logic                    hs_d1_r;
    logic                    vs_d1_r;
    logic [BYPASS_WIDTH-1:0] bypass_d1_r;

    // line_active_r is the delayed de_i: high means the stage-1 pixel is valid
    // and the current input pixel (if any) continues the same line.
    logic                    line_active_r;
    // Phase of the stage-1 pixel (0 = even / Cb slot, 1 = odd / Cr slot).
    logic                    phase_r;
    // Cr average computed while the even pixel sits in stage 1, emitted one
    // cycle later with the odd pixel.
    logic [W-1:0]            cr_avg_r;

    logic                    cur_phase_s;
    logic                    pair_start_s;
    logic [W-1:0]            c_next_s;

    // Phase of the incoming pixel and chroma value for the stage-1 pixel
    always_comb begin
        cur_phase_s  = 1'b0;
        pair_start_s = 1'b0;
        c_next_s     = {W{1'b0}};

        // A line start (previous cycle idle) always begins at phase 0.
        if (line_active_r) begin
            cur_phase_s = ~phase_r;
        end else begin
            cur_phase_s = 1'b0;
        end

        // Even pixel in stage 1 with its odd partner arriving right now.
        pair_start_s = line_active_r & ~phase_r & de_i;

        if (!line_active_r) begin
            c_next_s = {W{1'b0}};
        end else if (!phase_r) begin
            if (de_i) begin
                c_next_s = avg_round(cb_d1_r, cb_i);
            end else begin
                // Lone even pixel at the end of an odd-length line.
                c_next_s = cb_d1_r;
            end
        end else begin
            c_next_s = cr_avg_r;
        end
    end

    // Stage-1 registers, phase tracking and held Cr average
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_d1_r        <= {W{1'b0}};
            cb_d1_r       <= {W{1'b0}};
            cr_d1_r       <= {W{1'b0}};
            hs_d1_r       <= 1'b0;
            vs_d1_r       <= 1'b0;
            bypass_d1_r   <= {BYPASS_WIDTH{1'b0}};
            line_active_r <= 1'b0;
            phase_r       <= 1'b0;
            cr_avg_r      <= {W{1'b0}};
        end else begin
            y_d1_r        <= y_i;
            cb_d1_r       <= cb_i;
            cr_d1_r       <= cr_i;
            hs_d1_r       <= hs_i;
            vs_d1_r       <= vs_i;
            bypass_d1_r   <= bypass_i;
            line_active_r <= de_i;
            if (de_i) begin
                phase_r <= cur_phase_s;
            end else begin
                phase_r <= 1'b0;
            end
            if (pair_start_s) begin
                cr_avg_r <= avg_round(cr_d1_r, cr_i);
            end else begin
                cr_avg_r <= cr_avg_r;
            end
        end
    end

    // Stage-2 output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_o      <= {W{1'b0}};
            c_o      <= {W{1'b0}};
            de_o     <= 1'b0;
            hs_o     <= 1'b0;
            vs_o     <= 1'b0;
            bypass_o <= {BYPASS_WIDTH{1'b0}};
        end else begin
            y_o      <= y_d1_r;
            c_o      <= c_next_s;
            de_o     <= line_active_r;
            hs_o     <= hs_d1_r;
            vs_o     <= vs_d1_r;
            bypass_o <= bypass_d1_r;
        end
    end

endmodule

// File: doc/ycbcr444_to_422.md
YCBCR444_TO_422 -- requirements
Module: ycbcr444_to_422

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8: bits per component on all pixel ports.
REQ-002 Parameter BYPASS_WIDTH, default 8: width of the sideband bus delayed alongside the pixel.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset; deassertion synchronous to clk externally.
REQ-005 y_i  input  PIXEL_WIDTH  luma, unsigned.
REQ-006 cb_i  input  PIXEL_WIDTH  blue chroma, unsigned, offset-128 form.
REQ-007 cr_i  input  PIXEL_WIDTH  red chroma, unsigned, offset-128 form.
REQ-008 de_i / hs_i / vs_i  input  1 each  data enable, hsync, vsync, same cycle as pixel.
REQ-009 bypass_i  input  BYPASS_WIDTH  sideband, no processing.
REQ-010 y_o  output  PIXEL_WIDTH  luma, delayed.
REQ-011 c_o  output  PIXEL_WIDTH  interleaved chroma: Cb on even pixels, Cr on odd pixels.
REQ-012 de_o / hs_o / vs_o  output  1 each  delayed timing.
REQ-013 bypass_o  output  BYPASS_WIDTH  delayed sideband.

Function
REQ-014 The block SHALL convert 4:4:4 YCbCr to 4:2:2 with a fixed latency of 2 clk cycles from every input to its matching output; y_o, de_o, hs_o, vs_o and bypass_o SHALL equal the respective inputs delayed by exactly 2 cycles.
REQ-015 A pixel is any cycle with de_i=1; a line start is a pixel whose previous cycle had de_i=0.
REQ-016 Pixel phase SHALL be 0 (even) at each line start and SHALL toggle on every subsequent pixel of the line; phase does not advance when de_i=0.
REQ-017 For an even pixel n followed by pixel n+1 in the same line: c_o at pixel n SHALL be (cb[n]+cb[n+1]+1)>>1, and c_o at pixel n+1 SHALL be (cr[n]+cr[n+1]+1)>>1.
REQ-018 Sums SHALL be computed at PIXEL_WIDTH+1 bits; the result SHALL be truncated to PIXEL_WIDTH bits after the shift and can never overflow.
REQ-019 Odd-length line: an even pixel whose next input cycle has de_i=0 SHALL output c_o = cb of that pixel; its Cr is dropped.
REQ-020 A de_i gap inside a line ends that line; the next pixel is a new line start with phase 0.
REQ-021 When de_o=0, c_o SHALL be 0 and y_o SHALL carry the delayed y_i unchanged.
REQ-022 Pipeline state SHALL be a 2-deep shift register per signal plus a held Cr average register and a phase flag; no FSM states beyond the phase flag and a line-active flag.

Reset
REQ-023 While rst_n=0, every output SHALL be 0, the phase flag SHALL be 0, the line-active flag SHALL be 0, and all pipeline registers SHALL be 0.
REQ-024 Reset is asynchronous: outputs SHALL go to 0 without waiting for a clk edge.
REQ-025 Reset mid-line: the first cycle with rst_n=1 and de_i=1 SHALL be treated as a line start (phase 0), even if de_i was high during reset.
REQ-026 The first 2 cycles after reset deassertion SHALL output 0 on all ports (pipeline flush of reset contents).

Verification
REQ-027 Line of 4 pixels with cb = 10,20,30,41 and cr = 100,50,7,8 -> c_o = 15,75,36,8 on cycles 2..5 after the first pixel; de_o high for exactly those 4 cycles.
REQ-028 Odd line of 3 pixels with cb = 200,100,60 and cr = 1,3,90 -> c_o = 150,2,60; a following line starts at phase 0 (Cb first).
REQ-029 Extreme values cb=cr=255 on both pixels of a pair -> c_o = 255,255 with no wrap; cb=0,1 -> c_o = 1 (round half up).
REQ-030 Toggle hs_i, vs_i and bypass_i=0xA5 at arbitrary cycles, including during de_i=0 -> each appears on its output exactly 2 cycles later, unaltered.
REQ-031 Assert rst_n=0 asynchronously mid-pair (after even pixel, before odd) -> all outputs 0 immediately; after release, a 2-pixel line cb=8,12 cr=4,6 -> c_o = 10,5.
REQ-032 de_i pattern 1,1,0,1,1 with cb=2,4,x,6,10 and cr=2,4,x,6,10 -> c_o = 3,3,0,8,8; phase resets after the gap.
